// File: rtl/lora_frame_rx.sv
// rtl/lora_frame_rx.sv - tagged LoRa telemetry frame receiver with double-banked field RAM
module lora_frame_rx #(
    parameter int NUM_FIELDS    = 5,
    parameter int MAX_FIELD_LEN = 15,
    parameter int LEN_W         = 4,
    parameter int ADDR_W        = 6,
    parameter int TIMEOUT_CYC   = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic [ADDR_W:0]             ram_addr,
    output logic [7:0]                  ram_data,
    output logic                        ram_we,
    output logic                        rd_bank,
    output logic                        frame_valid,
    output logic [NUM_FIELDS*LEN_W-1:0] field_len,
    output logic                        frame_done_tick,
    output logic                        frame_err_tick,
    output logic                        ack_tick
);

    localparam int FIDX_W = $clog2(NUM_FIELDS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] TAG_A = 8'h41;
    localparam logic [7:0] TAG_V = 8'h56;

    typedef enum logic {S_IDLE, S_FIELD} state_t;

    state_t                      state_q, state_d;
    logic [FIDX_W-1:0]           fidx_q, fidx_d;
    logic [LEN_W-1:0]            flen_q, flen_d;
    logic [ADDR_W:0]             bidx_q, bidx_d;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic [LEN_W-1:0]            shadow_q [NUM_FIELDS];
    logic [LEN_W-1:0]            shadow_d [NUM_FIELDS];
    logic [ADDR_W:0]             ram_addr_q, ram_addr_d;
    logic [7:0]                  ram_data_q, ram_data_d;
    logic                        ram_we_q, ram_we_d;
    logic                        rd_bank_q, rd_bank_d;
    logic                        frame_valid_q, frame_valid_d;
    logic [NUM_FIELDS*LEN_W-1:0] field_len_q, field_len_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        ack_q, ack_d;
    logic [7:0]                  exp_tag;

    assign exp_tag = TAG_A + 8'(fidx_q) + 8'd1;

    always_comb begin
        state_d       = state_q;
        fidx_d        = fidx_q;
        flen_d        = flen_q;
        bidx_d        = bidx_q;
        tmo_d         = tmo_q;
        shadow_d      = shadow_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_we_d      = 1'b0;
        rd_bank_d     = rd_bank_q;
        frame_valid_d = frame_valid_q;
        field_len_d   = field_len_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        ack_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (rx_data == TAG_A) begin
                        ack_d   = 1'b1;
                        fidx_d  = '0;
                        flen_d  = '0;
                        bidx_d  = '0;
                        state_d = S_FIELD;
                    end else if (rx_data == TAG_V) begin
                        frame_valid_d = 1'b0;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            S_FIELD: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (rx_data == TAG_A) begin
                        err_d  = 1'b1;
                        ack_d  = 1'b1;
                        fidx_d = '0;
                        flen_d = '0;
                        bidx_d = '0;
                    end else if (rx_data == exp_tag) begin
                        if (flen_q == '0) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            for (int k = 0; k < NUM_FIELDS; k++) begin
                                if (fidx_q == FIDX_W'(k)) shadow_d[k] = flen_q;
                            end
                            if (fidx_q == FIDX_W'(NUM_FIELDS - 1)) begin
                                // Publish: bank swap and lengths move together on one edge.
                                rd_bank_d     = ~rd_bank_q;
                                frame_valid_d = 1'b1;
                                done_d        = 1'b1;
                                state_d       = S_IDLE;
                                for (int k = 0; k < NUM_FIELDS; k++) begin
                                    field_len_d[k*LEN_W +: LEN_W] = shadow_d[k];
                                end
                            end else begin
                                fidx_d = fidx_q + FIDX_W'(1);
                                flen_d = '0;
                            end
                        end
                    end else if (flen_q == LEN_W'(MAX_FIELD_LEN) || bidx_q[ADDR_W]) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ram_addr_d = {~rd_bank_q, bidx_q[ADDR_W-1:0]};
                        ram_data_d = rx_data;
                        ram_we_d   = 1'b1;
                        bidx_d     = bidx_q + (ADDR_W+1)'(1);
                        flen_d     = flen_q + LEN_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Count would reach TIMEOUT_CYC on this silent cycle.
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fidx_q        <= '0;
            flen_q        <= '0;
            bidx_q        <= '0;
            tmo_q         <= '0;
            shadow_q      <= '{default: '0};
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_we_q      <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            field_len_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fidx_q        <= fidx_d;
            flen_q        <= flen_d;
            bidx_q        <= bidx_d;
            tmo_q         <= tmo_d;
            shadow_q      <= shadow_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_we_q      <= ram_we_d;
            rd_bank_q     <= rd_bank_d;
            frame_valid_q <= frame_valid_d;
            field_len_q   <= field_len_d;
            done_q        <= done_d;
            err_q         <= err_d;
            ack_q         <= ack_d;
        end
    end

    assign ram_addr        = ram_addr_q;
    assign ram_data        = ram_data_q;
    assign ram_we          = ram_we_q;
    assign rd_bank         = rd_bank_q;
    assign frame_valid     = frame_valid_q;
    assign field_len       = field_len_q;
    assign frame_done_tick = done_q;
    assign frame_err_tick  = err_q;
    assign ack_tick        = ack_q;

endmodule

// File: tb/tb_lora_frame_rx.sv
// tb/tb_lora_frame_rx.sv - directed-vector bench for lora_frame_rx (default, short-timeout and small-bank instances)
module tb_lora_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx_v [3];
    logic [7:0] rx_d [3];

    logic [6:0]  addr0;
    logic [7:0]  data0;
    logic        we0, rb0, fv0, done0, err0, ack0;
    logic [19:0] fl0;
    logic [6:0]  addr1;
    logic [7:0]  data1;
    logic        we1, rb1, fv1, done1, err1, ack1;
    logic [19:0] fl1;
    logic [3:0]  addr2;
    logic [7:0]  data2;
    logic        we2, rb2, fv2, done2, err2, ack2;
    logic [7:0]  fl2;

    lora_frame_rx dut0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_v[0]), .rx_data(rx_d[0]),
        .ram_addr(addr0), .ram_data(data0), .ram_we(we0), .rd_bank(rb0),
        .frame_valid(fv0), .field_len(fl0), .frame_done_tick(done0),
        .frame_err_tick(err0), .ack_tick(ack0)
    );

    lora_frame_rx #(.TIMEOUT_CYC(100)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_v[1]), .rx_data(rx_d[1]),
        .ram_addr(addr1), .ram_data(data1), .ram_we(we1), .rd_bank(rb1),
        .frame_valid(fv1), .field_len(fl1), .frame_done_tick(done1),
        .frame_err_tick(err1), .ack_tick(ack1)
    );

    lora_frame_rx #(.NUM_FIELDS(2), .ADDR_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_v[2]), .rx_data(rx_d[2]),
        .ram_addr(addr2), .ram_data(data2), .ram_we(we2), .rd_bank(rb2),
        .frame_valid(fv2), .field_len(fl2), .frame_done_tick(done2),
        .frame_err_tick(err2), .ack_tick(ack2)
    );

    logic [6:0] wa0 [$];
    logic [7:0] wd0 [$];
    logic [3:0] wa2 [$];
    int done_c0 = 0, err_c0 = 0, ack_c0 = 0;
    int done_c1 = 0, err_c1 = 0, ack_c1 = 0;
    int done_c2 = 0, err_c2 = 0, ack_c2 = 0, we_c1 = 0;

    always @(negedge clk) begin
        if (we0) begin
            wa0.push_back(addr0);
            wd0.push_back(data0);
        end
        if (we2) wa2.push_back(addr2);
        if (we1)   we_c1   <= we_c1 + 1;
        if (done0) done_c0 <= done_c0 + 1;
        if (err0)  err_c0  <= err_c0 + 1;
        if (ack0)  ack_c0  <= ack_c0 + 1;
        if (done1) done_c1 <= done_c1 + 1;
        if (err1)  err_c1  <= err_c1 + 1;
        if (ack1)  ack_c1  <= ack_c1 + 1;
        if (done2) done_c2 <= done_c2 + 1;
        if (err2)  err_c2  <= err_c2 + 1;
        if (ack2)  ack_c2  <= ack_c2 + 1;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        rx_v[d] = 1'b1;
        rx_d[d] = b;
        @(posedge clk);
        #1;
        rx_v[d] = 1'b0;
    endtask

    task automatic send_str(input int d, input string s);
        for (int i = 0; i < s.len(); i++) send(d, s[i]);
    endtask

    task automatic test_reset;
        nvec++; if (addr0 !== 7'h00 || data0 !== 8'h00 || we0 !== 1'b0) begin
            nerr++; $display("FAIL reset_ram: addr=%0h data=%0h we=%0b expected 0/0/0", addr0, data0, we0); end
        nvec++; if (rb0 !== 1'b0 || fv0 !== 1'b0 || fl0 !== 20'h0) begin
            nerr++; $display("FAIL reset_pub: rd_bank=%0b fv=%0b fl=%0h expected 0/0/0", rb0, fv0, fl0); end
        nvec++; if (done0 !== 1'b0 || err0 !== 1'b0 || ack0 !== 1'b0) begin
            nerr++; $display("FAIL reset_ticks: done=%0b err=%0b ack=%0b expected 0/0/0", done0, err0, ack0); end
    endtask

    task automatic test_good_frame;
        int w, dn, ak;
        w = wa0.size(); dn = done_c0; ak = ack_c0;
        send_str(0, "A12B345C6D78E9F");
        idle(2);
        nvec++; if (wa0.size() - w !== 9) begin
            nerr++; $display("FAIL good_wr_count: got %0d expected 9", wa0.size() - w); end
        for (int i = 0; i < 9 && w + i < wa0.size(); i++) begin
            nvec++;
            if (wa0[w+i] !== 7'(8'h40 + i) || wd0[w+i] !== 8'(8'h31 + i)) begin
                nerr++; $display("FAIL good_wr%0d: addr=%0h data=%0h expected %0h/%0h",
                                 i, wa0[w+i], wd0[w+i], 8'h40 + i, 8'h31 + i);
            end
        end
        nvec++; if (done_c0 - dn !== 1) begin
            nerr++; $display("FAIL good_done: got %0d pulses expected 1", done_c0 - dn); end
        nvec++; if (rb0 !== 1'b1 || fv0 !== 1'b1) begin
            nerr++; $display("FAIL good_pub: rd_bank=%0b fv=%0b expected 1/1", rb0, fv0); end
        nvec++; if (fl0 !== 20'h12132) begin
            nerr++; $display("FAIL good_len: got %0h expected 12132", fl0); end
        nvec++; if (ack_c0 - ak !== 1) begin
            nerr++; $display("FAIL good_ack: got %0d expected 1", ack_c0 - ak); end
    endtask

    task automatic test_second_frame;
        int w, ak;
        w = wa0.size();
        send_str(0, "A9B8C7D6E5F");
        idle(2);
        nvec++; if (wa0.size() - w !== 5) begin
            nerr++; $display("FAIL second_wr_count: got %0d expected 5", wa0.size() - w); end
        for (int i = 0; i < 5 && w + i < wa0.size(); i++) begin
            nvec++;
            if (wa0[w+i] !== 7'(i) || wd0[w+i] !== 8'(8'h39 - i)) begin
                nerr++; $display("FAIL second_wr%0d: addr=%0h data=%0h expected %0h/%0h",
                                 i, wa0[w+i], wd0[w+i], i, 8'h39 - i);
            end
        end
        nvec++; if (rb0 !== 1'b0 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL second_pub: rd_bank=%0b fv=%0b fl=%0h expected 0/1/11111", rb0, fv0, fl0); end
        ak = ack_c0;
        send(0, "V");
        idle(2);
        nvec++; if (fv0 !== 1'b0 || ack_c0 - ak !== 0) begin
            nerr++; $display("FAIL v_clear: fv=%0b acks=%0d expected 0/0", fv0, ack_c0 - ak); end
        ak = ack_c0;
        send(0, "x");
        idle(2);
        nvec++; if (ack_c0 - ak !== 1 || fv0 !== 1'b0) begin
            nerr++; $display("FAIL idle_ack: acks=%0d fv=%0b expected 1/0", ack_c0 - ak, fv0); end
    endtask

    task automatic test_errors;
        int er, dn, w, ak;
        send_str(0, "A1B2C3D4E5F");
        idle(2);
        nvec++; if (rb0 !== 1'b1 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL err_setup: rd_bank=%0b fv=%0b fl=%0h expected 1/1/11111", rb0, fv0, fl0); end

        er = err_c0; dn = done_c0;
        send_str(0, "A1BC");
        idle(2);
        nvec++; if (err_c0 - er !== 1 || done_c0 - dn !== 0) begin
            nerr++; $display("FAIL empty_field: errs=%0d dones=%0d expected 1/0", err_c0 - er, done_c0 - dn); end
        nvec++; if (rb0 !== 1'b1 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL empty_keep: rd_bank=%0b fv=%0b fl=%0h expected 1/1/11111", rb0, fv0, fl0); end

        er = err_c0; w = wa0.size();
        send(0, "A");
        for (int i = 0; i < 16; i++) send(0, "x");
        idle(2);
        nvec++; if (err_c0 - er !== 1 || wa0.size() - w !== 15) begin
            nerr++; $display("FAIL long_field: errs=%0d writes=%0d expected 1/15", err_c0 - er, wa0.size() - w); end
        nvec++; if (rb0 !== 1'b1 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL long_keep: rd_bank=%0b fv=%0b fl=%0h expected 1/1/11111", rb0, fv0, fl0); end

        er = err_c0; dn = done_c0; ak = ack_c0;
        send_str(0, "A12A");
        idle(2);
        nvec++; if (err_c0 - er !== 1 || ack_c0 - ak !== 2) begin
            nerr++; $display("FAIL resync: errs=%0d acks=%0d expected 1/2", err_c0 - er, ack_c0 - ak); end
        nvec++; if (rb0 !== 1'b1 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL resync_keep: rd_bank=%0b fv=%0b fl=%0h expected 1/1/11111", rb0, fv0, fl0); end
        w = wa0.size();
        send_str(0, "1B2C3D4E5F");
        idle(2);
        nvec++; if (done_c0 - dn !== 1 || err_c0 - er !== 1 || rb0 !== 1'b0 || fv0 !== 1'b1) begin
            nerr++; $display("FAIL resync_done: dones=%0d errs=%0d rd_bank=%0b fv=%0b expected 1/1/0/1",
                             done_c0 - dn, err_c0 - er, rb0, fv0); end
        nvec++; if (wa0.size() - w !== 5 || (wa0.size() > w && wa0[w] !== 7'h00)) begin
            nerr++; $display("FAIL resync_addr: writes=%0d expected 5 starting at 0", wa0.size() - w); end
    endtask

    task automatic test_timeout;
        int er, dn, hit;
        er = err_c1;
        hit = 0;
        send_str(1, "A12");
        for (int k = 1; k <= 200 && hit == 0; k++) begin
            @(posedge clk);
            #1;
            if (err1) hit = k;
        end
        nvec++; if (hit !== 100) begin
            nerr++; $display("FAIL timeout_cycle: err after %0d cycles (0 = none) expected 100", hit); end
        idle(2);
        nvec++; if (err_c1 - er !== 1) begin
            nerr++; $display("FAIL timeout_once: got %0d pulses expected 1", err_c1 - er); end

        er = err_c1; dn = done_c1;
        send_str(1, "A12");
        idle(99);
        send(1, "x");
        nvec++; if (err1 !== 1'b0) begin
            nerr++; $display("FAIL timeout_race: err=%0b expected 0", err1); end
        send_str(1, "B3C4D5E6F");
        idle(2);
        nvec++; if (err_c1 - er !== 0 || done_c1 - dn !== 1 || fl1 !== 20'h11113) begin
            nerr++; $display("FAIL timeout_race_done: errs=%0d dones=%0d fl=%0h expected 0/1/11113",
                             err_c1 - er, done_c1 - dn, fl1); end
    endtask

    task automatic test_overflow;
        int er, dn, w;
        er = err_c2; dn = done_c2; w = wa2.size();
        send_str(2, "A12345B6789");
        nvec++; if (err2 !== 1'b1) begin
            nerr++; $display("FAIL ovf_at_9th: err=%0b expected 1", err2); end
        idle(2);
        nvec++; if (err_c2 - er !== 1 || done_c2 - dn !== 0 || wa2.size() - w !== 8) begin
            nerr++; $display("FAIL ovf_counts: errs=%0d dones=%0d writes=%0d expected 1/0/8",
                             err_c2 - er, done_c2 - dn, wa2.size() - w); end
        nvec++; if (rb2 !== 1'b0 || fv2 !== 1'b0 || fl2 !== 8'h00) begin
            nerr++; $display("FAIL ovf_keep: rd_bank=%0b fv=%0b fl=%0h expected 0/0/0", rb2, fv2, fl2); end
        w = wa2.size();
        send_str(2, "A1234B567C");
        idle(2);
        nvec++; if (done_c2 - dn !== 1 || fl2 !== 8'h34 || rb2 !== 1'b1 || fv2 !== 1'b1) begin
            nerr++; $display("FAIL two_field: dones=%0d fl=%0h rd_bank=%0b fv=%0b expected 1/34/1/1",
                             done_c2 - dn, fl2, rb2, fv2); end
        nvec++; if (wa2.size() - w !== 7 || (wa2.size() == w + 7 && (wa2[w] !== 4'h8 || wa2[w+6] !== 4'he))) begin
            nerr++; $display("FAIL two_field_addr: writes=%0d expected 7 over 8..e", wa2.size() - w); end
    endtask

    task automatic test_reset_mid_frame;
        int dn, w;
        send_str(0, "A12");
        rx_v[0] = 1'b1;
        rx_d[0] = "3";
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rx_v[0] = 1'b0;
        nvec++; if (we0 !== 1'b0 || fv0 !== 1'b0 || addr0 !== 7'h00 || data0 !== 8'h00) begin
            nerr++; $display("FAIL rst_mid_ram: we=%0b fv=%0b addr=%0h data=%0h expected 0/0/0/0", we0, fv0, addr0, data0); end
        nvec++; if (rb0 !== 1'b0 || fl0 !== 20'h0 || err0 !== 1'b0 || done0 !== 1'b0 || ack0 !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_pub: rd_bank=%0b fl=%0h err=%0b done=%0b ack=%0b expected 0", rb0, fl0, err0, done0, ack0); end
        rst_n = 1'b1;
        idle(1);
        dn = done_c0; w = wa0.size();
        send_str(0, "A1B2C3D4E5F");
        idle(2);
        nvec++; if (done_c0 - dn !== 1 || rb0 !== 1'b1 || fv0 !== 1'b1 || fl0 !== 20'h11111) begin
            nerr++; $display("FAIL rst_mid_next: dones=%0d rd_bank=%0b fv=%0b fl=%0h expected 1/1/1/11111",
                             done_c0 - dn, rb0, fv0, fl0); end
        nvec++; if (wa0.size() - w !== 5 || (wa0.size() > w && wa0[w] !== 7'h40)) begin
            nerr++; $display("FAIL rst_mid_addr: writes=%0d expected 5 starting at 40", wa0.size() - w); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_v[i] = 1'b0;
            rx_d[i] = 8'h00;
        end
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        test_reset;
        test_good_frame;
        test_second_frame;
        test_errors;
        test_timeout;
        test_overflow;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
